// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the fetch/data memory port arbiter.
//   state_e  : transaction sequencer states
//   OWN_IF / OWN_DM : owner encoding (fetch = 0, data = 1)
//   to_word  : assemble two bytes (byte0 from a, byte1 from a+1) into a word
//   lane     : pick the word byte that belongs at address a or a+1
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        CAP  = 2'd3
    } state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // byte0 was read from address a, byte1 from address a+1.
    function automatic logic [15:0] to_word(input logic [7:0] byte0,
                                            input logic [7:0] byte1,
                                            input logic       big_endian);
        return big_endian ? {byte0, byte1} : {byte1, byte0};
    endfunction

    // second = 0 selects the byte stored at a, second = 1 the byte at a+1.
    function automatic logic [7:0] lane(input logic [15:0] word,
                                        input logic        second,
                                        input logic        big_endian);
        return (second ^ big_endian) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Requester-side bundle of the arbiter: the fetch port (if_*) and the
// load/store port (dm_*).
//   master : the control unit / datapath side (drives requests)
//   slave  : the arbiter side (returns read data and done pulses)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;

    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  if_rdata, if_done, dm_rdata, dm_done
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output if_rdata, if_done, dm_rdata, dm_done
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational grant selection between the fetch and data requesters.
//   if_req_i / dm_req_i   : raw requests
//   if_mask_i / dm_mask_i : port is in its done cycle; its request is ignored
//   rr_last_i             : last granted port (only with MEM_ARB_RR_EN)
//   gnt_valid_o           : some unmasked request is present
//   gnt_owner_o           : winning port (OWN_IF / OWN_DM)
// Build option MEM_ARB_RR_EN: round-robin on a tie instead of data priority.
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic if_mask_i,
    input  logic dm_mask_i,
`ifdef MEM_ARB_RR_EN
    input  logic rr_last_i,
`endif
    output logic gnt_valid_o,
    output logic gnt_owner_o
);

    logic if_ok;
    logic dm_ok;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        if_ok       = if_req_i && !if_mask_i;
        dm_ok       = dm_req_i && !dm_mask_i;
        gnt_valid_o = if_ok || dm_ok;
`ifdef MEM_ARB_RR_EN
        // Owner codes are 0/1, so inverting the last owner names the other port.
        if (if_ok && dm_ok) gnt_owner_o = ~rr_last_i;
        else                gnt_owner_o = dm_ok ? OWN_DM : OWN_IF;
`else
        gnt_owner_o = dm_ok ? OWN_DM : OWN_IF;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one 8-bit synchronous byte RAM (1-cycle read latency) between the
// instruction-fetch and load/store requesters. Each 16-bit word is moved as
// two byte accesses (a, then a+1 with wrap) with per-port byte order, and the
// owner gets a one-cycle done pulse with the assembled word.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_if (slave)   : fetch and data request/response bundle
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i : byte RAM port
//   busy_o           : transaction in flight (state != IDLE)
//   owner_o          : current or last granted port (0 fetch, 1 data)
// Build option MEM_ARB_RR_EN: round-robin arbitration on simultaneous requests.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter bit IF_BIG_ENDIAN = 1'b1,
    parameter bit DM_BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave req_if,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    state_e            state_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [15:0]       wdata_q;
    logic [7:0]        byte0_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              busy_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic [15:0]       if_rdata_q;
    logic [15:0]       dm_rdata_q;

    logic              gnt_valid;
    logic              gnt_owner;
    logic [ADDR_W-1:0] grant_addr_d;
    logic              grant_we_d;
    logic [15:0]       grant_wdata_d;
    logic [ADDR_W-1:0] addr_inc_d;
    logic              port_big_d;
    logic [15:0]       word_d;

`ifdef MEM_ARB_RR_EN
    logic rr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             rr_q <= OWN_IF;
        else if (state_q == IDLE && gnt_valid)  rr_q <= gnt_owner;
    end
`endif

    // The port in its done cycle is masked so a request that has not dropped
    // yet cannot start a duplicate access.
    mem_arb_pick u_pick (
        .if_req_i    (req_if.if_req),
        .dm_req_i    (req_if.dm_req),
        .if_mask_i   (if_done_q),
        .dm_mask_i   (dm_done_q),
`ifdef MEM_ARB_RR_EN
        .rr_last_i   (rr_q),
`endif
        .gnt_valid_o (gnt_valid),
        .gnt_owner_o (gnt_owner)
    );

    always_comb begin
        grant_addr_d  = (gnt_owner == OWN_DM) ? req_if.dm_addr[ADDR_W-1:0]
                                              : req_if.if_addr[ADDR_W-1:0];
        // The fetch port never writes, whatever the data port is doing.
        grant_we_d    = (gnt_owner == OWN_DM) && req_if.dm_we;
        grant_wdata_d = (gnt_owner == OWN_DM) ? req_if.dm_wdata : 16'h0000;
        addr_inc_d    = addr_q + ADDR_W'(1);
        port_big_d    = (owner_q == OWN_DM) ? DM_BIG_ENDIAN : IF_BIG_ENDIAN;
        // In CAP, mem_rdata_i carries the byte read from a+1.
        word_d        = to_word(byte0_q, mem_rdata_i, port_big_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= 16'h0000;
            byte0_q     <= 8'h00;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= 16'h0000;
            dm_rdata_q  <= 16'h0000;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        state_q     <= ACC0;
                        owner_q     <= gnt_owner;
                        addr_q      <= grant_addr_d;
                        we_q        <= grant_we_d;
                        wdata_q     <= grant_wdata_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_we_d;
                        mem_addr_q  <= grant_addr_d;
                        mem_wdata_q <= lane(grant_wdata_d, 1'b0, DM_BIG_ENDIAN);
                        busy_q      <= 1'b1;
                    end
                end
                ACC0: begin
                    state_q     <= ACC1;
                    mem_addr_q  <= addr_inc_d;
                    mem_wdata_q <= lane(wdata_q, 1'b1, DM_BIG_ENDIAN);
                end
                ACC1: begin
                    state_q  <= CAP;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    byte0_q  <= mem_rdata_i;
                end
                CAP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_rdata_q <= word_d;
                        if_done_q  <= 1'b1;
                    end else begin
                        if (!we_q) dm_rdata_q <= word_d;
                        dm_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en_o        = mem_en_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign busy_o          = busy_q;
    assign owner_o         = owner_q;
    assign req_if.if_rdata = if_rdata_q;
    assign req_if.if_done  = if_done_q;
    assign req_if.dm_rdata = dm_rdata_q;
    assign req_if.dm_done  = dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Bench for mem_port_arbiter with a behavioural byte RAM (1-cycle read
// latency) and a word-level reference model of memory contents, arbitration
// order and completion timing.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        owner;

    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    int          n_cmp = 0;
    int          n_err = 0;
    int          we_viol = 0;
    logic [15:0] exp_if_rd;
    logic [15:0] exp_dm_rd;
    logic        last_owner;
    logic [15:0] addr_log [$];

    typedef struct {
        bit          fetch;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [9];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .ADDR_W        (16),
        .IF_BIG_ENDIAN (1'b1),
        .DM_BIG_ENDIAN (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_if      (bus),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy),
        .owner_o     (owner)
    );

    always #5 clk = ~clk;

    // Byte RAM with a preload port used only while the DUT is in reset.
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    always @(negedge clk)
        if (rst_n && mem_we && (owner == 1'b0)) we_viol++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pl_byte(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Reference model: word view of memory per port byte order.
    function automatic logic [15:0] ref_read(input logic [15:0] a, input bit big);
        logic [15:0] nxt = a + 16'd1;
        if (big) return {ref_mem[a], ref_mem[nxt]};
        return {ref_mem[nxt], ref_mem[a]};
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [15:0] w, input bit big);
        logic [15:0] nxt = a + 16'd1;
        if (big) begin ref_mem[a] = w[15:8]; ref_mem[nxt] = w[7:0]; end
        else     begin ref_mem[a] = w[7:0];  ref_mem[nxt] = w[15:8]; end
    endtask

    function automatic bit dm_wins_tie();
`ifdef MEM_ARB_RR_EN
        return last_owner == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_if(input logic [15:0] a);
        exp_if_rd  = ref_read(a, 1'b1);
        last_owner = 1'b0;
    endtask

    task automatic model_dm(input bit we, input logic [15:0] a, input logic [15:0] wd);
        if (we) ref_write(a, wd, 1'b0);
        else    exp_dm_rd = ref_read(a, 1'b0);
        last_owner = 1'b1;
    endtask

    // Raise the requested ports together, then check done timing cycle by cycle.
    // Each request is held through the edge that ends its done cycle.
    task automatic run_txn(input bit do_if, input logic [15:0] ia,
                           input bit do_dm, input bit dwe,
                           input logic [15:0] da, input logic [15:0] dwd,
                           output logic [15:0] got_if, output logic [15:0] got_dm);
        int k_if = 0;
        int k_dm = 0;
        int k_end;
        bit dm_first;
        dm_first = do_dm && (!do_if || dm_wins_tie());
        if (dm_first) begin
            k_dm = 4; model_dm(dwe, da, dwd);
            if (do_if) begin k_if = 8; model_if(ia); end
        end else if (do_if) begin
            k_if = 4; model_if(ia);
            if (do_dm) begin k_dm = 8; model_dm(dwe, da, dwd); end
        end
        k_end = ((k_if > k_dm) ? k_if : k_dm) + 4;
        got_if = 16'hxxxx;
        got_dm = 16'hxxxx;
        @(negedge clk);
        bus.if_req = do_if; bus.if_addr = ia;
        bus.dm_req = do_dm; bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dwd;
        addr_log.delete();
        for (int k = 1; k <= k_end; k++) begin
            @(posedge clk); #1;
            if (k == k_if + 1) bus.if_req = 1'b0;
            if (k == k_dm + 1) bus.dm_req = 1'b0;
            @(negedge clk);
            if (mem_en) addr_log.push_back(mem_addr);
            check("if_done", 32'(bus.if_done), 32'(k == k_if));
            check("dm_done", 32'(bus.dm_done), 32'(k == k_dm));
            if (k == k_if) begin
                got_if = bus.if_rdata;
                check("if_rdata", 32'(bus.if_rdata), 32'(exp_if_rd));
            end
            if (k == k_dm) begin
                got_dm = bus.dm_rdata;
                check("dm_rdata", 32'(bus.dm_rdata), 32'(exp_dm_rd));
            end
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        check("busy_idle", 32'(busy), 32'd0);
        check("owner", 32'(owner), 32'(last_owner));
    endtask

    initial begin
        logic [15:0] gi, gd;
        logic [1:0]  sel;
        bit          rw;
        logic [15:0] ra;

        rst_n = 1'b0;
        pl_en = 1'b0; pl_addr = 16'h0; pl_data = 8'h0;
        bus.if_req = 1'b0; bus.if_addr = 16'h0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 16'h0; bus.dm_wdata = 16'h0;
        exp_if_rd = 16'h0; exp_dm_rd = 16'h0; last_owner = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h3412};
        vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        vecs[2] = '{1'b0, 1'b1, 16'h0020, 16'hBEEF, 16'h1234};
        vecs[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hEFBE};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hABCD};
        vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hCDAB};
        vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 16'h5566, 16'hCDAB};
        vecs[8] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h6655};

        repeat (2) @(negedge clk);
        check("rst_mem_en",    32'(mem_en),       32'd0);
        check("rst_mem_we",    32'(mem_we),       32'd0);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_owner",     32'(owner),        32'd0);
        check("rst_if_done",   32'(bus.if_done),  32'd0);
        check("rst_dm_done",   32'(bus.dm_done),  32'd0);
        check("rst_mem_addr",  32'(mem_addr),     32'd0);
        check("rst_mem_wdata", 32'(mem_wdata),    32'd0);
        check("rst_if_rdata",  32'(bus.if_rdata), 32'd0);
        check("rst_dm_rdata",  32'(bus.dm_rdata), 32'd0);

        pl_byte(16'h0010, 8'h34);
        pl_byte(16'h0011, 8'h12);
        pl_byte(16'hFFFF, 8'hAB);
        pl_byte(16'h0000, 8'hCD);
        pl_byte(16'h0030, 8'h11);
        pl_byte(16'h0031, 8'h22);
        for (int i = 16'h40; i < 16'h50; i++) pl_byte(16'(i), 8'($urandom));
        @(negedge clk);
        rst_n = 1'b1;

        // Single-port vectors.
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].fetch, vecs[i].addr, !vecs[i].fetch, vecs[i].we,
                    vecs[i].addr, vecs[i].wdata, gi, gd);
            check($sformatf("vec%0d", i), 32'(vecs[i].fetch ? gi : gd), 32'(vecs[i].exp));
        end
        check("ram_0020", 32'(ram[16'h0020]), 32'h00EF);
        check("ram_0021", 32'(ram[16'h0021]), 32'h00BE);
        check("ram_ffff", 32'(ram[16'hFFFF]), 32'h0066);
        check("ram_0000", 32'(ram[16'h0000]), 32'h0055);

        // Address wrap on the second byte of a load.
        run_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFFF, 16'h0, gi, gd);
        check("wrap_word", 32'(gd), 32'h5566);
        check("wrap_nacc", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() == 2) begin
            check("wrap_a0", 32'(addr_log[0]), 32'hFFFF);
            check("wrap_a1", 32'(addr_log[1]), 32'h0000);
        end

        // Simultaneous requests; last owner is data here.
        run_txn(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0010, 16'h0, gi, gd);
        check("tie_if", 32'(gi), 32'h3412);
        check("tie_dm", 32'(gd), 32'h1234);
        run_txn(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0020, 16'hCAFE, gi, gd);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(1, 3));
            rw  = 1'($urandom);
            ra  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(16'h40, 16'h4E));
            run_txn(sel[0], 16'($urandom_range(16'h40, 16'h4E)), sel[1], rw, ra,
                    16'($urandom), gi, gd);
        end

        // Reset during ACC1 of a store: first byte written, second not, no done.
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0030; bus.dm_wdata = 16'hBEEF;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_busy",   32'(busy),   32'd0);
        bus.dm_req = 1'b0;
        ref_mem[16'h0030] = 8'hEF;
        exp_if_rd = 16'h0; exp_dm_rd = 16'h0; last_owner = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            check("abort_no_done", 32'(bus.dm_done), 32'd0);
        end
        check("abort_0030", 32'(ram[16'h0030]), 32'h00EF);
        check("abort_0031", 32'(ram[16'h0031]), 32'h0022);
        check("abort_dm_rdata", 32'(bus.dm_rdata), 32'(exp_dm_rd));
        run_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0, gi, gd);
        check("abort_word", 32'(gd), 32'h22EF);

        check("fetch_never_writes", 32'(we_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one 8-bit-wide, single-ported, synchronous byte memory between the instruction-fetch requester (PC/IR path) and the data requester (load/store path, ALUOut-addressed). Sequences each 16-bit word access as two byte accesses and applies per-port byte order. Returns the assembled word with a one-cycle done pulse. Sits between the multi-cycle control unit/datapath and the unified byte RAM, replacing the split instruction/data memories.

Parameters:
ADDR_W, 16, byte address width to the memory; requester addresses are truncated to ADDR_W.
IF_BIG_ENDIAN, 1, fetch port byte order: 1 gives word = {mem[a], mem[a+1]}.
DM_BIG_ENDIAN, 0, data port byte order: 0 gives word = {mem[a+1], mem[a]}.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_done
if_addr  in  16  fetch byte address; stable while if_req is high
if_rdata  out  16  fetched word; valid when if_done is high, held until the next fetch completes
if_done  out  1  one-cycle completion pulse
dm_req  in  1  data request; held high until dm_done
dm_we  in  1  1 = store, 0 = load; stable while dm_req is high
dm_addr  in  16  data byte address
dm_wdata  in  16  store data
dm_rdata  out  16  load word; valid when dm_done is high, held until the next load completes
dm_done  out  1  one-cycle completion pulse
mem_en  out  1  memory access enable
mem_we  out  1  memory byte write enable
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  8  memory write byte
mem_rdata  in  8  read byte, valid in the cycle after mem_en with mem_we=0 (1-cycle latency)
busy  out  1  high in every state except IDLE
owner  out  1  0 = fetch, 1 = data; the current or last granted port

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_en, mem_we, if_done, dm_done, busy = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; owner = 0; round-robin pointer = fetch.
- FSM states: IDLE, ACC0, ACC1, CAP. Transitions: IDLE to ACC0 when any unmasked request is present; ACC0 to ACC1; ACC1 to CAP; CAP to IDLE. No stalls.
- IDLE: arbitrate, then latch owner, address, we and wdata into internal registers. Requester inputs are not sampled again during the transaction.
- Priority without the optional feature: data port wins a simultaneous request. Fetch is never starved in the multi-cycle flow because the two requesters do not overlap indefinitely.
- ACC0: mem_en=1, mem_addr=a. For a store, mem_we=1 and mem_wdata = the first byte in port order (DM_BIG_ENDIAN=0 sends the low byte first).
- ACC1: mem_en=1, mem_addr=(a+1) mod 2^ADDR_W; the address wraps, e.g. 0xFFFF becomes 0x0000. A store writes the second byte. A load captures mem_rdata as byte0.
- CAP: mem_en=0. A load captures byte1 and assembles the word per the owner's endianness. The read-data register of the owning port updates at the end of CAP.
- done: registered. The owner's done is high for exactly the one cycle after CAP, and the read data is valid in that same cycle. Stores also pulse done; dm_rdata is unchanged by a store.
- Latency: request sampled at an IDLE edge gives done 4 cycles later. Back-to-back throughput is 1 word per 4 cycles.
- Done-cycle mask: in the cycle its done is high, the just-served port's req is ignored; the other port may be granted that cycle. This prevents a duplicate access from a req that has not yet dropped.
- The fetch port never writes; mem_we is 0 whenever owner = fetch.
- Reset mid-operation: everything aborts immediately and no done is issued. A store interrupted after ACC0 leaves the first byte written and the second byte unwritten; software must treat that word as undefined.
- A request deasserted mid-transaction is illegal. The transaction completes anyway and done still pulses.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. On a simultaneous request, the port not served last wins, and the pointer updates on each grant.
- Undefined: fixed priority, with the data port winning, as specified above.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACC0, ACC1, CAP}
  - owner encoding constants OWN_IF=0, OWN_DM=1
  - byte-order helper function: (byte0, byte1, big_endian) to word
- One sub-module, mem_arb_pick: combinational grant selection from the two requests, the done-cycle mask and the RR pointer. The pointer register lives in the parent.

Test Plan:
- Memory 0x0010=0x34, 0x0011=0x12; if_req, if_addr=0x0010 -> if_done 4 cycles later, if_rdata=0x3412, mem_we never 1.
- Same memory; dm_req load at 0x0010 -> dm_done 4 cycles later, dm_rdata=0x1234.
- Store dm_addr=0x0020, dm_wdata=0xBEEF -> ACC0 writes 0xEF to 0x0020, ACC1 writes 0xBE to 0x0021; dm_done pulses; dm_rdata unchanged.
- if_req and dm_req rise in the same cycle -> data is served first, then fetch starts in dm_done's cycle; fetch done 4 cycles after that. With MEM_ARB_RR_EN and the last owner = data, fetch is served first.
- Load at 0xFFFF with ADDR_W=16 -> second access goes to mem_addr=0x0000, and the word is assembled correctly.
- Store 0xBEEF to 0x0030; drop rst_n during ACC1 -> immediately mem_en=0, busy=0, no dm_done; 0x0030=0xEF, 0x0031 unchanged.
